// File: rtl/input_port_vc_buffer_pkg.sv
// Helpers shared by the input-port VC buffer and its per-VC FIFO.
// Pointer wrap is computed against the real depth so non-power-of-2
// depths wrap from DEPTH-1 back to 0 instead of running off the end.
package input_port_vc_buffer_pkg;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    int unsigned nxt;
    if (ptr >= (depth - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/std_dffrve.sv
// Generic enable flop with asynchronous active-low reset to a fixed value.
module std_dffrve #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, otherwise hold; reset clears asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/vc_flit_fifo.sv
// Single virtual-channel flit FIFO. Write/read enables arrive already
// qualified (no write when full, no read when empty), so this block only
// tracks pointers, occupancy and a registered non-empty flag. Storage is
// deliberately not reset; the head data is only meaningful when head_vld=1.
module vc_flit_fifo
  import input_port_vc_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic              head_vld,
  output logic [DATA_W-1:0] head_dat,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [CNT_W-1:0]  occ_r;
  logic [CNT_W-1:0]  occ_nxt_s;
  logic              not_empty_r;
  logic              not_empty_nxt_s;

  // Next pointers, occupancy and empty flag from the qualified enables.
  always_comb begin
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    occ_nxt_s       = occ_r;
    not_empty_nxt_s = not_empty_r;
    if (wr_en) begin
      wr_ptr_nxt_s = PTR_W'(ptr_next(32'(wr_ptr_r), 32'(DEPTH)));
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_en) begin
      rd_ptr_nxt_s = PTR_W'(ptr_next(32'(rd_ptr_r), 32'(DEPTH)));
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({wr_en, rd_en})
      2'b10:   occ_nxt_s = occ_r + CNT_W'(1);
      2'b01:   occ_nxt_s = occ_r - CNT_W'(1);
      default: occ_nxt_s = occ_r;
    endcase
    not_empty_nxt_s = (occ_nxt_s != '0);
  end

  // Flit storage, written at the write pointer; never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_dat;
    end
  end

  std_dffrve #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk(clk), .rstn(rstn), .en(wr_en), .d(wr_ptr_nxt_s), .q(wr_ptr_r)
  );

  std_dffrve #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk(clk), .rstn(rstn), .en(rd_en), .d(rd_ptr_nxt_s), .q(rd_ptr_r)
  );

  std_dffrve #(.WIDTH(CNT_W)) u_occ (
    .clk(clk), .rstn(rstn), .en(1'b1), .d(occ_nxt_s), .q(occ_r)
  );

  std_dffrve #(.WIDTH(1)) u_not_empty (
    .clk(clk), .rstn(rstn), .en(1'b1), .d(not_empty_nxt_s), .q(not_empty_r)
  );

  assign head_vld  = not_empty_r;
  assign head_dat  = mem_r[rd_ptr_r];
  assign occupancy = occ_r;

endmodule

// File: rtl/input_port_vc_buffer.sv
// Router input-port buffer: one FIFO per virtual channel, one write and one
// pop per cycle. Accepted pops return a registered credit upstream; dropped
// writes (VC full) and ignored pops (VC empty) raise one-cycle error pulses.
// Full/empty are judged on the pre-cycle state, so a same-VC write+pop on a
// full VC drops the write while the pop still completes.
module input_port_vc_buffer
  import input_port_vc_buffer_pkg::*;
#(
  parameter int VC_NUM             = 4,
  parameter int VC_NUM_IDX_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int VC_DEPTH           = 2,
  parameter int VC_DEPTH_COUNTER_W = $clog2(VC_DEPTH + 1),
  parameter int FLIT_W             = 64
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 flit_vld_i,
  input  logic [VC_NUM_IDX_W-1:0]              flit_vc_id_i,
  input  logic [FLIT_W-1:0]                    flit_dat_i,
  output logic [VC_NUM-1:0]                    vc_head_vld_o,
  output logic [VC_NUM*FLIT_W-1:0]             vc_head_dat_o,
  input  logic                                 pop_vld_i,
  input  logic [VC_NUM_IDX_W-1:0]              pop_vc_id_i,
  output logic [VC_NUM*VC_DEPTH_COUNTER_W-1:0] vc_occupancy_o,
  output logic                                 free_vc_credit_vld_o,
  output logic [VC_NUM_IDX_W-1:0]              free_vc_credit_vc_id_o,
  output logic                                 err_overflow_o,
  output logic                                 err_underflow_o
);

  logic [VC_NUM-1:0]             wr_sel_s;
  logic [VC_NUM-1:0]             rd_sel_s;
  logic [VC_NUM-1:0]             full_s;
  logic [VC_NUM-1:0]             empty_s;
  logic [VC_NUM-1:0]             wr_en_s;
  logic [VC_NUM-1:0]             rd_en_s;
  logic [VC_NUM-1:0]             head_vld_s;
  logic [VC_DEPTH_COUNTER_W-1:0] occ_s [VC_NUM];
  logic                          ovf_nxt_s;
  logic                          udf_nxt_s;
  logic                          cred_nxt_s;

  // Decode the target VCs and qualify write/pop against pre-cycle state.
  always_comb begin
    wr_sel_s = '0;
    rd_sel_s = '0;
    full_s   = '0;
    empty_s  = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      wr_sel_s[i] = flit_vld_i & (flit_vc_id_i == VC_NUM_IDX_W'(i));
      rd_sel_s[i] = pop_vld_i & (pop_vc_id_i == VC_NUM_IDX_W'(i));
      full_s[i]   = (occ_s[i] == VC_DEPTH_COUNTER_W'(VC_DEPTH));
      empty_s[i]  = ~head_vld_s[i];
    end
    wr_en_s    = wr_sel_s & ~full_s;
    rd_en_s    = rd_sel_s & ~empty_s;
    ovf_nxt_s  = |(wr_sel_s & full_s);
    udf_nxt_s  = |(rd_sel_s & empty_s);
    cred_nxt_s = |rd_en_s;
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    vc_flit_fifo #(
      .DEPTH (VC_DEPTH),
      .DATA_W(FLIT_W),
      .CNT_W (VC_DEPTH_COUNTER_W)
    ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_en_s[g]),
      .wr_dat   (flit_dat_i),
      .rd_en    (rd_en_s[g]),
      .head_vld (head_vld_s[g]),
      .head_dat (vc_head_dat_o[g*FLIT_W +: FLIT_W]),
      .occupancy(occ_s[g])
    );
    assign vc_occupancy_o[g*VC_DEPTH_COUNTER_W +: VC_DEPTH_COUNTER_W] = occ_s[g];
  end

  assign vc_head_vld_o = head_vld_s;

  std_dffrve #(.WIDTH(1)) u_cred_vld (
    .clk(clk), .rstn(rstn), .en(1'b1), .d(cred_nxt_s), .q(free_vc_credit_vld_o)
  );

  // The id only loads with a real credit so it stays stable while idle.
  std_dffrve #(.WIDTH(VC_NUM_IDX_W)) u_cred_id (
    .clk(clk), .rstn(rstn), .en(cred_nxt_s), .d(pop_vc_id_i), .q(free_vc_credit_vc_id_o)
  );

  std_dffrve #(.WIDTH(1)) u_err_ovf (
    .clk(clk), .rstn(rstn), .en(1'b1), .d(ovf_nxt_s), .q(err_overflow_o)
  );

  std_dffrve #(.WIDTH(1)) u_err_udf (
    .clk(clk), .rstn(rstn), .en(1'b1), .d(udf_nxt_s), .q(err_underflow_o)
  );

endmodule

// File: tb/tb_input_port_vc_buffer.sv
// Scoreboard bench for input_port_vc_buffer (4 VCs, depth 2, 64-bit flits).
// The driver updates a queue model and pushes time-stamped expected credit
// and error events; a monitor after each rising edge pops and compares.
module tb_input_port_vc_buffer;

  localparam int VN = 4;
  localparam int IW = 2;
  localparam int VD = 2;
  localparam int CW = 2;
  localparam int FW = 64;

  logic              clk;
  logic              rstn;
  logic              flit_vld_i;
  logic [IW-1:0]     flit_vc_id_i;
  logic [FW-1:0]     flit_dat_i;
  logic [VN-1:0]     vc_head_vld_o;
  logic [VN*FW-1:0]  vc_head_dat_o;
  logic              pop_vld_i;
  logic [IW-1:0]     pop_vc_id_i;
  logic [VN*CW-1:0]  vc_occupancy_o;
  logic              free_vc_credit_vld_o;
  logic [IW-1:0]     free_vc_credit_vc_id_o;
  logic              err_overflow_o;
  logic              err_underflow_o;

  input_port_vc_buffer #(
    .VC_NUM(VN), .VC_NUM_IDX_W(IW), .VC_DEPTH(VD), .VC_DEPTH_COUNTER_W(CW), .FLIT_W(FW)
  ) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .flit_vld_i            (flit_vld_i),
    .flit_vc_id_i          (flit_vc_id_i),
    .flit_dat_i            (flit_dat_i),
    .vc_head_vld_o         (vc_head_vld_o),
    .vc_head_dat_o         (vc_head_dat_o),
    .pop_vld_i             (pop_vld_i),
    .pop_vc_id_i           (pop_vc_id_i),
    .vc_occupancy_o        (vc_occupancy_o),
    .free_vc_credit_vld_o  (free_vc_credit_vld_o),
    .free_vc_credit_vc_id_o(free_vc_credit_vc_id_o),
    .err_overflow_o        (err_overflow_o),
    .err_underflow_o       (err_underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int stamp; int id;} cred_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] mq [VN][$];
  cred_t       cred_q[$];
  int          ovf_q[$];
  int          udf_q[$];
  int          up_cred [VN];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] head(input int v);
    return vc_head_dat_o[v*FW +: FW];
  endfunction

  function automatic logic [63:0] occ(input int v);
    return 64'(vc_occupancy_o[v*CW +: CW]);
  endfunction

  // One cycle of stimulus; model uses the state before this cycle.
  task automatic step(input bit fv, input int fid, input logic [63:0] fd,
                      input bit pv, input int pid);
    bit full;
    bit empty;
    @(negedge clk);
    if (free_vc_credit_vld_o) up_cred[free_vc_credit_vc_id_o]++;
    flit_vld_i   = fv;
    flit_vc_id_i = IW'(fid);
    flit_dat_i   = fd;
    pop_vld_i    = pv;
    pop_vc_id_i  = IW'(pid);
    full  = (mq[fid].size() == VD);
    empty = (mq[pid].size() == 0);
    if (pv) begin
      if (empty) udf_q.push_back(cyc + 1);
      else begin
        cred_q.push_back('{cyc + 1, pid});
        void'(mq[pid].pop_front());
      end
    end
    if (fv) begin
      if (full) ovf_q.push_back(cyc + 1);
      else mq[fid].push_back(fd);
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 64'd0, 1'b0, 0);
  endtask

  // Monitor: after each rising edge compare events and head/occupancy.
  initial begin
    cred_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rstn) begin
        if (cred_q.size() > 0 && cred_q[0].stamp == cyc) begin
          e = cred_q.pop_front();
          chk("credit_vld", 64'(free_vc_credit_vld_o), 64'd1);
          chk("credit_id", 64'(free_vc_credit_vc_id_o), 64'(e.id));
        end else begin
          chk("credit_quiet", 64'(free_vc_credit_vld_o), 64'd0);
        end
        if (ovf_q.size() > 0 && ovf_q[0] == cyc) begin
          void'(ovf_q.pop_front());
          chk("ovf_pulse", 64'(err_overflow_o), 64'd1);
        end else begin
          chk("ovf_quiet", 64'(err_overflow_o), 64'd0);
        end
        if (udf_q.size() > 0 && udf_q[0] == cyc) begin
          void'(udf_q.pop_front());
          chk("udf_pulse", 64'(err_underflow_o), 64'd1);
        end else begin
          chk("udf_quiet", 64'(err_underflow_o), 64'd0);
        end
        for (int v = 0; v < VN; v++) begin
          chk("occupancy", occ(v), 64'(mq[v].size()));
          chk("head_vld", 64'(vc_head_vld_o[v]), 64'(mq[v].size() > 0));
          if (mq[v].size() > 0) chk("head_dat", head(v), mq[v][0]);
        end
      end
    end
  end

  initial begin
    int fid;
    int pid;
    bit fv;
    bit pv;
    rstn = 1'b0;
    flit_vld_i = 1'b0; flit_vc_id_i = '0; flit_dat_i = '0;
    pop_vld_i = 1'b0; pop_vc_id_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_head_vld", 64'(vc_head_vld_o), 64'd0);
    chk("rst_occ", 64'(vc_occupancy_o), 64'd0);
    chk("rst_credit", 64'(free_vc_credit_vld_o), 64'd0);
    chk("rst_errs", 64'({err_overflow_o, err_underflow_o}), 64'd0);
    rstn = 1'b1;

    // Single write into VC2.
    step(1'b1, 2, 64'hA5, 1'b0, 0);
    idle();
    chk("wr2_head_vld", 64'(vc_head_vld_o), 64'h4);
    chk("wr2_head_dat", head(2), 64'hA5);
    chk("wr2_occ", occ(2), 64'd1);

    // Fill VC1, third write dropped.
    step(1'b1, 1, 64'h11, 1'b0, 0);
    step(1'b1, 1, 64'h12, 1'b0, 0);
    step(1'b1, 1, 64'h13, 1'b0, 0);
    idle();
    chk("ovf_dir_pulse", 64'(err_overflow_o), 64'd1);
    chk("ovf_dir_occ", occ(1), 64'd2);
    chk("ovf_dir_head", head(1), 64'h11);
    idle();
    chk("ovf_dir_clear", 64'(err_overflow_o), 64'd0);

    // Back-to-back pops of VC1.
    step(1'b0, 0, 64'd0, 1'b1, 1);
    step(1'b0, 0, 64'd0, 1'b1, 1);
    chk("pop1_cred", 64'({free_vc_credit_vld_o, free_vc_credit_vc_id_o}), 64'b101);
    chk("pop1_head", head(1), 64'h12);
    idle();
    chk("pop2_cred", 64'({free_vc_credit_vld_o, free_vc_credit_vc_id_o}), 64'b101);
    chk("pop2_empty", 64'(vc_head_vld_o[1]), 64'd0);

    // Same-cycle write and pop on VC0 holding one flit.
    step(1'b1, 0, 64'h20, 1'b0, 0);
    step(1'b1, 0, 64'h21, 1'b1, 0);
    idle();
    chk("wp0_occ", occ(0), 64'd1);
    chk("wp0_head", head(0), 64'h21);
    chk("wp0_cred", 64'({free_vc_credit_vld_o, free_vc_credit_vc_id_o}), 64'b100);

    // Pop of empty VC3.
    step(1'b0, 0, 64'd0, 1'b1, 3);
    idle();
    chk("udf_dir_pulse", 64'(err_underflow_o), 64'd1);
    chk("udf_dir_nocred", 64'(free_vc_credit_vld_o), 64'd0);

    // Write VC3 while popping VC2; then write to full VC3 with a same-cycle pop.
    step(1'b1, 3, 64'h33, 1'b1, 2);
    step(1'b1, 3, 64'h34, 1'b0, 0);
    step(1'b1, 3, 64'h35, 1'b1, 3);
    // Pop of empty VC2 with same-cycle write to VC2.
    step(1'b1, 2, 64'h77, 1'b1, 2);
    idle();
    idle();
    chk("mix_occ3", occ(3), 64'd1);
    chk("mix_head3", head(3), 64'h34);

    // Reset while a pop is in flight.
    @(negedge clk);
    flit_vld_i = 1'b0;
    pop_vld_i = 1'b1; pop_vc_id_i = 2'd3;
    #2 rstn = 1'b0;
    for (int v = 0; v < VN; v++) mq[v].delete();
    cred_q.delete(); ovf_q.delete(); udf_q.delete();
    #1;
    pop_vld_i = 1'b0;
    chk("mid_rst_occ", 64'(vc_occupancy_o), 64'd0);
    chk("mid_rst_vld", 64'(vc_head_vld_o), 64'd0);
    @(negedge clk);
    chk("mid_rst_cred", 64'(free_vc_credit_vld_o), 64'd0);
    rstn = 1'b1;
    idle();
    chk("post_rst_cred", 64'(free_vc_credit_vld_o), 64'd0);
    idle();

    // Loop-back traffic against an upstream credit counter model.
    for (int v = 0; v < VN; v++) up_cred[v] = VD;
    for (int n = 0; n < 10000; n++) begin
      fid = int'($urandom_range(0, VN - 1));
      fv  = (up_cred[fid] > 0) && ($urandom_range(0, 3) != 0);
      if (fv) up_cred[fid]--;
      pid = int'($urandom_range(0, VN - 1));
      pv  = (mq[pid].size() > 0) && ($urandom_range(0, 1) == 1);
      step(fv, fid, 64'({$urandom, $urandom}), pv, pid);
    end
    for (int n = 0; n < 16; n++) begin
      pv = 1'b0;
      pid = 0;
      for (int v = 0; v < VN; v++) begin
        if (!pv && mq[v].size() > 0) begin
          pv = 1'b1;
          pid = v;
        end
      end
      step(1'b0, 0, 64'd0, pv, pid);
    end
    idle();
    idle();
    idle();
    for (int v = 0; v < VN; v++) chk("upstream_credit", 64'(up_cred[v]), 64'd2);
    chk("cred_q_drained", 64'(cred_q.size()), 64'd0);
    chk("err_q_drained", 64'(ovf_q.size() + udf_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
